sound_event_scheduler: RTL



---
 rtl/sound_event_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/sound_event_scheduler.sv
// Buzzer sequencer: fixed-priority arbitration of cube-beep and game-over jingle
// requests, producing a registered square wave of programmed pitch and duration.
module sound_event_scheduler #(
  parameter int CUBE_HALF    = 56818,
  parameter int CUBE_LEN     = 5000000,
  parameter int FINAL_A_HALF = 113636,
  parameter int FINAL_B_HALF = 227272,
  parameter int FINAL_LEN    = 25000000,
  parameter int HALF_W       = 18,
  parameter int LEN_W        = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_cubo,
  input  logic       req_final,
  input  logic       mute,
  output logic       sound_out,
  output logic       busy,
  output logic [1:0] sound_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CUBE    = 2'd1,
    S_FINAL_A = 2'd2,
    S_FINAL_B = 2'd3
  } state_t;

  localparam logic [HALF_W-1:0] CUBE_HALF_M = HALF_W'(CUBE_HALF - 1);
  localparam logic [HALF_W-1:0] FA_HALF_M   = HALF_W'(FINAL_A_HALF - 1);
  localparam logic [HALF_W-1:0] FB_HALF_M   = HALF_W'(FINAL_B_HALF - 1);
  localparam logic [LEN_W-1:0]  CUBE_LEN_M  = LEN_W'(CUBE_LEN - 1);
  localparam logic [LEN_W-1:0]  FINAL_LEN_M = LEN_W'(FINAL_LEN - 1);

  state_t              r_state, w_state;
  logic [HALF_W-1:0]   r_half, w_half;
  logic [LEN_W-1:0]    r_dur, w_dur;
  logic                r_tone, w_tone;
  logic                r_sound;
  logic                r_busy;
  logic [HALF_W-1:0]   w_half_max;
  logic [LEN_W-1:0]    w_len_max;

  always_comb begin
    w_half_max = '0;
    w_len_max  = '0;
    case (r_state)
      S_CUBE:    begin w_half_max = CUBE_HALF_M; w_len_max = CUBE_LEN_M;  end
      S_FINAL_A: begin w_half_max = FA_HALF_M;   w_len_max = FINAL_LEN_M; end
      S_FINAL_B: begin w_half_max = FB_HALF_M;   w_len_max = FINAL_LEN_M; end
      default:   begin w_half_max = '0;          w_len_max = '0;          end
    endcase
  end

  // Every state entry (including a restart of the same sound) begins on the high phase.
  always_comb begin
    w_state = r_state;
    w_half  = r_half;
    w_dur   = r_dur;
    w_tone  = r_tone;
    if (req_final) begin
      w_state = S_FINAL_A;
      w_half  = '0;
      w_dur   = '0;
      w_tone  = 1'b1;
    end else if (req_cubo && (r_state == S_IDLE || r_state == S_CUBE)) begin
      w_state = S_CUBE;
      w_half  = '0;
      w_dur   = '0;
      w_tone  = 1'b1;
    end else if (r_state == S_IDLE) begin
      w_half  = '0;
      w_dur   = '0;
      w_tone  = 1'b0;
    end else if (r_dur == w_len_max) begin
      w_half = '0;
      w_dur  = '0;
      if (r_state == S_FINAL_A) begin
        w_state = S_FINAL_B;
        w_tone  = 1'b1;
      end else begin
        w_state = S_IDLE;
        w_tone  = 1'b0;
      end
    end else begin
      w_dur = r_dur + 1'b1;
      if (r_half == w_half_max) begin
        w_half = '0;
        w_tone = ~r_tone;
      end else begin
        w_half = r_half + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_half  <= '0;
      r_dur   <= '0;
      r_tone  <= 1'b0;
      r_sound <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_half  <= w_half;
      r_dur   <= w_dur;
      r_tone  <= w_tone;
      r_sound <= w_tone & ~mute;
      r_busy  <= (w_state != S_IDLE);
    end
  end

  assign sound_out = r_sound;
  assign busy      = r_busy;
  assign sound_id  = r_state;

endmodule
